buf_replica_pingpong: RTL and testbench

Double-buffered, multi-port replicated frame buffer for the frequency-domain datapath. It accepts one beat of 2*FFTCHNL complex words per cycle from the FFT stage and assembles a frame of 2^INDXLEN words into a ping-pong bank pair. REPLICA independent read ports each read any address of the completed bank while the other bank fills. It generalises the single-bank replica buffer with frame-level ready/valid/done handshakes and per-port read enables.

---
 rtl/buf_replica_pkg.sv | 26 ++
 rtl/buf_replica_bank.sv | 48 ++++
 rtl/buf_replica_pingpong.sv | 175 +++++++++++++++++
 tb/tb_buf_replica_pingpong.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_replica_pkg.sv
// Shared parameters, word type and read-latency constant for the ping-pong replica buffer.
// BUFREP_OUTREG_EN selects the extra output register stage (read latency 2 instead of 1).
package buf_replica_pkg;

  localparam int DATALEN_DEF = 16;
  localparam int FFTCHNL_DEF = 8;
  localparam int REPLICA_DEF = 8;
  localparam int INDXLEN_DEF = 6;

  typedef struct packed {
    logic [DATALEN_DEF-1:0] re;
    logic [DATALEN_DEF-1:0] im;
  } cplx_t;

  // Beats per frame: frame depth divided by words per beat.
  function automatic int calc_beats(input int indxlen, input int fftchnl);
    return (1 << indxlen) / (2 * fftchnl);
  endfunction

`ifdef BUFREP_OUTREG_EN
  localparam int BUFREP_RD_LAT = 2;
`else
  localparam int BUFREP_RD_LAT = 1;
`endif

endpackage

// File: rtl/buf_replica_bank.sv
// One frame bank: a wide write port taking IN_WORDS consecutive words per beat,
// and REPLICA independent registered read ports. Memory contents are not reset.
module buf_replica_bank
  import buf_replica_pkg::*;
#(
  parameter int DATALEN  = DATALEN_DEF,
  parameter int IN_WORDS = 2 * FFTCHNL_DEF,
  parameter int REPLICA  = REPLICA_DEF,
  parameter int INDXLEN  = INDXLEN_DEF,
  parameter int BCW      = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 wen,
  input  logic [BCW-1:0]                       wbeat,
  input  logic [0:IN_WORDS-1][2*DATALEN-1:0]   wdata,
  input  logic [0:REPLICA-1]                   rden,
  input  logic [0:REPLICA-1][INDXLEN-1:0]      raddr,
  output logic [0:REPLICA-1][2*DATALEN-1:0]    rdata
);

  localparam int DEPTH = 1 << INDXLEN;

  logic [2*DATALEN-1:0] mem [DEPTH];

  // Beat b occupies words b*IN_WORDS .. b*IN_WORDS+IN_WORDS-1.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int k = 0; k < IN_WORDS; k++) begin
        mem[INDXLEN'(int'(wbeat) * IN_WORDS + k)] <= wdata[k];
      end
    end
  end

  // Read registers update only on an enabled read, so they hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else begin
      for (int p = 0; p < REPLICA; p++) begin
        if (rden[p]) begin
          rdata[p] <= mem[raddr[p]];
        end
      end
    end
  end

endmodule

// File: rtl/buf_replica_pingpong.sv
// Ping-pong replicated frame buffer: one bank fills from the FFT stage while REPLICA ports
// read the completed bank. BUFREP_OUTREG_EN (via the package) adds an output register stage.
module buf_replica_pingpong
  import buf_replica_pkg::*;
#(
  parameter int DATALEN = DATALEN_DEF,
  parameter int FFTCHNL = FFTCHNL_DEF,
  parameter int REPLICA = REPLICA_DEF,
  parameter int INDXLEN = INDXLEN_DEF
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       invalid,
  output logic                                       inready,
  input  logic [0:2*FFTCHNL-1][2*DATALEN-1:0]        indata,
  output logic                                       outvalid,
  input  logic                                       outdone,
  input  logic [0:REPLICA-1]                         outrden,
  input  logic [0:REPLICA-1][INDXLEN-1:0]            outaddr,
  output logic [0:REPLICA-1][2*DATALEN-1:0]          outdata,
  output logic [0:REPLICA-1]                         outdvalid
);

  localparam int IN_WORDS = 2 * FFTCHNL;
  localparam int DEPTH    = 1 << INDXLEN;
  localparam int BEATS    = calc_beats(INDXLEN, FFTCHNL);
  localparam int BCW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int W        = 2 * DATALEN;

  if ((DEPTH < IN_WORDS) || ((DEPTH % IN_WORDS) != 0)) begin : g_depth_check
    $error("buf_replica_pingpong: DEPTH must be a multiple of IN_WORDS");
  end

  logic           wbank_r, wbank_n;
  logic           rbank_r, rbank_n;
  logic [1:0]     full_r, full_n;
  logic [BCW-1:0] bcnt_r, bcnt_n;
  logic           wr_fire_s, wr_last_s, rel_s;

  assign inready  = ~full_r[wbank_r];
  assign outvalid = full_r[rbank_r];

  // Bank state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbank_r <= 1'b0;
      rbank_r <= 1'b0;
      full_r  <= 2'b00;
      bcnt_r  <= '0;
    end else begin
      wbank_r <= wbank_n;
      rbank_r <= rbank_n;
      full_r  <= full_n;
      bcnt_r  <= bcnt_n;
    end
  end

  // Set and clear always target different banks, so both may apply in one cycle.
  always_comb begin
    wr_fire_s = invalid & ~full_r[wbank_r];
    wr_last_s = (bcnt_r == BCW'(BEATS - 1));
    rel_s     = outdone & full_r[rbank_r];
    full_n    = full_r;
    wbank_n   = wbank_r;
    rbank_n   = rbank_r;
    bcnt_n    = bcnt_r;
    if (wr_fire_s) begin
      if (wr_last_s) begin
        bcnt_n          = '0;
        full_n[wbank_r] = 1'b1;
        wbank_n         = ~wbank_r;
      end else begin
        bcnt_n = bcnt_r + BCW'(1);
      end
    end else begin
      bcnt_n = bcnt_r;
    end
    if (rel_s) begin
      full_n[rbank_r] = 1'b0;
      rbank_n         = ~rbank_r;
    end else begin
      rbank_n = rbank_r;
    end
  end

  logic [0:REPLICA-1]         issue_s;
  logic                       bank_wen_s   [2];
  logic [0:REPLICA-1]         bank_rden_s  [2];
  logic [0:REPLICA-1][W-1:0]  bank_rdata_s [2];

  // Route the write beat to wbank and each enabled read to rbank.
  always_comb begin
    issue_s = outrden & {REPLICA{outvalid}};
    for (int b = 0; b < 2; b++) begin
      bank_wen_s[b]  = wr_fire_s & (wbank_r == b[0]);
      bank_rden_s[b] = (rbank_r == b[0]) ? issue_s : '0;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    buf_replica_bank #(
      .DATALEN (DATALEN),
      .IN_WORDS(IN_WORDS),
      .REPLICA (REPLICA),
      .INDXLEN (INDXLEN),
      .BCW     (BCW)
    ) u_bank (
      .clk  (clk),
      .rstn (rstn),
      .wen  (bank_wen_s[b]),
      .wbeat(bcnt_r),
      .wdata(indata),
      .rden (bank_rden_s[b]),
      .raddr(outaddr),
      .rdata(bank_rdata_s[b])
    );
  end

  logic [0:REPLICA-1]         rsel_r;
  logic [0:REPLICA-1]         dvalid_r;
  logic [0:REPLICA-1][W-1:0]  rdata_s;

  // Bank choice is captured at issue so a same-cycle release cannot redirect the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsel_r   <= '0;
      dvalid_r <= '0;
    end else begin
      dvalid_r <= issue_s;
      for (int p = 0; p < REPLICA; p++) begin
        if (issue_s[p]) begin
          rsel_r[p] <= rbank_r;
        end
      end
    end
  end

  // Data-time bank mux.
  always_comb begin
    for (int p = 0; p < REPLICA; p++) begin
      if (rsel_r[p]) begin
        rdata_s[p] = bank_rdata_s[1][p];
      end else begin
        rdata_s[p] = bank_rdata_s[0][p];
      end
    end
  end

  if (BUFREP_RD_LAT > 1) begin : g_outreg
    logic [0:REPLICA-1][W-1:0] odata_r;
    logic [0:REPLICA-1]        odvalid_r;

    // Extra output stage; data holds while no valid read arrives.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        odata_r   <= '0;
        odvalid_r <= '0;
      end else begin
        odvalid_r <= dvalid_r;
        for (int p = 0; p < REPLICA; p++) begin
          if (dvalid_r[p]) begin
            odata_r[p] <= rdata_s[p];
          end
        end
      end
    end

    assign outdata   = odata_r;
    assign outdvalid = odvalid_r;
  end else begin : g_direct
    assign outdata   = rdata_s;
    assign outdvalid = dvalid_r;
  end

endmodule

// File: tb/tb_buf_replica_pingpong.sv
// Self-checking bench for buf_replica_pingpong: directed scenarios plus random traffic,
// checked against a frame-queue model (a FIFO of up to two completed frames).
module tb_buf_replica_pingpong;

  localparam int DATALEN  = 16;
  localparam int FFTCHNL  = 8;
  localparam int REPLICA  = 8;
  localparam int INDXLEN  = 6;
  localparam int IN_WORDS = 16;
  localparam int DEPTH    = 64;
  localparam int BEATS    = 4;
`ifdef BUFREP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic invalid = 1'b0;
  logic outdone = 1'b0;
  logic inready, outvalid;
  logic [0:IN_WORDS-1][31:0]       indata = '0;
  logic [0:REPLICA-1]              outrden = '0;
  logic [0:REPLICA-1][INDXLEN-1:0] outaddr = '0;
  logic [0:REPLICA-1][31:0]        outdata;
  logic [0:REPLICA-1]              outdvalid;

  int n_checks = 0;
  int n_fail   = 0;

  buf_replica_pingpong #(
    .DATALEN(DATALEN), .FFTCHNL(FFTCHNL), .REPLICA(REPLICA), .INDXLEN(INDXLEN)
  ) dut (
    .clk(clk), .rstn(rstn), .invalid(invalid), .inready(inready), .indata(indata),
    .outvalid(outvalid), .outdone(outdone), .outrden(outrden), .outaddr(outaddr),
    .outdata(outdata), .outdvalid(outdvalid)
  );

  always #5 clk = ~clk;

  typedef logic [31:0] frame_t [DEPTH];
  frame_t      fq[$];
  frame_t      fill;
  int          nbeats;
  logic        m_v [REPLICA];
  logic [31:0] m_d [REPLICA];
  logic        pv  [REPLICA][LAT];
  logic [31:0] pd  [REPLICA][LAT];

  task automatic model_reset();
    fq.delete();
    nbeats = 0;
    for (int p = 0; p < REPLICA; p++) begin
      m_v[p] = 1'b0;
      m_d[p] = 32'd0;
      for (int s = 0; s < LAT; s++) begin
        pv[p][s] = 1'b0;
        pd[p][s] = 32'd0;
      end
    end
  endtask

  // Advance one clock and update the model with the inputs present before the edge.
  task automatic tick();
    logic acc, rel;
    logic rv [REPLICA];
    logic [31:0] rd [REPLICA];
    frame_t front;
    acc = invalid && (fq.size() < 2);
    rel = outdone && (fq.size() > 0);
    if (fq.size() > 0) front = fq[0];
    else front = '{default: 32'd0};
    for (int p = 0; p < REPLICA; p++) begin
      rv[p] = outrden[p] && (fq.size() > 0);
      rd[p] = front[outaddr[p]];
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < REPLICA; p++) begin
      for (int s = LAT - 1; s > 0; s--) begin
        pv[p][s] = pv[p][s-1];
        pd[p][s] = pd[p][s-1];
      end
      pv[p][0] = rv[p];
      pd[p][0] = rd[p];
      m_v[p] = pv[p][LAT-1];
      if (m_v[p]) m_d[p] = pd[p][LAT-1];
    end
    if (acc) begin
      for (int k = 0; k < IN_WORDS; k++) fill[nbeats*IN_WORDS + k] = indata[k];
      nbeats++;
    end
    if (rel) void'(fq.pop_front());
    if (acc && nbeats == BEATS) begin
      fq.push_back(fill);
      nbeats = 0;
    end
  endtask

  task automatic set_idle();
    invalid = 1'b0;
    outdone = 1'b0;
    outrden = '0;
  endtask

  // Drive one frame; tag=0 gives random words, otherwise {tag+b, k}.
  task automatic send_frame(input logic [15:0] tag);
    for (int b = 0; b < BEATS; b++) begin
      invalid = 1'b1;
      for (int k = 0; k < IN_WORDS; k++)
        indata[k] = (tag == 16'd0) ? $urandom() : {16'(tag + 16'(b)), 16'(k)};
      tick();
    end
    invalid = 1'b0;
  endtask

  task automatic issue_reads();
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 1) outrden = '0;
    end
  endtask

  task automatic release_frame();
    outdone = 1'b1;
    tick();
    outdone = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (inready !== 1'b1) begin n_fail++; $display("FAIL reset_inready got %b want 1", inready); end
    n_checks++; if (outvalid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %b want 0", outvalid); end
    for (int p = 0; p < REPLICA; p++) begin
      n_checks++; if (outdvalid[p] !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid[%0d] got %b want 0", p, outdvalid[p]); end
      n_checks++; if (outdata[p] !== 32'd0) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 0", p, outdata[p]); end
    end
    rstn = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [31:0] exp [REPLICA];
    int b, k;
    for (int bb = 0; bb < BEATS; bb++) begin
      invalid = 1'b1;
      for (int kk = 0; kk < IN_WORDS; kk++) indata[kk] = {16'(bb), 16'(kk)};
      tick();
      n_checks++; if (outvalid !== (bb == BEATS - 1)) begin n_fail++; $display("FAIL single_outvalid beat %0d got %b", bb, outvalid); end
    end
    invalid = 1'b0;
    for (int p = 0; p < REPLICA; p++) begin
      b = $urandom_range(0, 3);
      k = $urandom_range(0, 15);
      outaddr[p] = INDXLEN'(16 * b + k);
      exp[p] = {16'(b), 16'(k)};
    end
    outrden = '1;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 1) outrden = '0;
      for (int p = 0; p < REPLICA; p++) begin
        n_checks++; if (outdvalid[p] !== (t == LAT)) begin n_fail++; $display("FAIL single_latency port %0d cyc %0d got %b", p, t, outdvalid[p]); end
        if (t == LAT) begin
          n_checks++; if (outdata[p] !== exp[p]) begin n_fail++; $display("FAIL single_data port %0d got %h want %h", p, outdata[p], exp[p]); end
        end
      end
    end
    release_frame();
    n_checks++; if (outvalid !== 1'b0 || inready !== 1'b1) begin n_fail++; $display("FAIL single_release got ov=%b rdy=%b want 0/1", outvalid, inready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [REPLICA];
    send_frame(16'd0);
    send_frame(16'd0);
    n_checks++; if (inready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", inready); end
    for (int b = 0; b < BEATS; b++) begin
      invalid = 1'b1;
      for (int k = 0; k < IN_WORDS; k++) indata[k] = $urandom();
      tick();
      n_checks++; if (inready !== 1'b0) begin n_fail++; $display("FAIL b2b_third got %b want 0", inready); end
    end
    invalid = 1'b0;
    release_frame();
    n_checks++; if (inready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_return got %b want 1", inready); end
    n_checks++; if (outvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_ov_frame2 got %b want 1", outvalid); end
    for (int p = 0; p < REPLICA; p++) begin
      outaddr[p] = INDXLEN'($urandom_range(0, DEPTH - 1));
      exp[p] = fq[0][outaddr[p]];
    end
    outrden = '1;
    issue_reads();
    for (int p = 0; p < REPLICA; p++) begin
      n_checks++; if (outdvalid[p] !== 1'b1 || outdata[p] !== exp[p]) begin n_fail++; $display("FAIL b2b_read port %0d got %b/%h want 1/%h", p, outdvalid[p], outdata[p], exp[p]); end
    end
    release_frame();
  endtask

  task automatic test_multi_port();
    logic [31:0] exp [REPLICA];
    send_frame(16'd0);
    for (int p = 0; p < REPLICA; p++) begin
      outaddr[p] = INDXLEN'(9 * p);
      exp[p] = fq[0][9 * p];
    end
    outrden = '1;
    issue_reads();
    for (int p = 0; p < REPLICA; p++) begin
      n_checks++; if (outdvalid[p] !== 1'b1 || outdata[p] !== exp[p]) begin n_fail++; $display("FAIL multi_read port %0d got %b/%h want 1/%h", p, outdvalid[p], outdata[p], exp[p]); end
    end
    for (int p = 0; p < REPLICA; p++) begin
      outaddr[p] = INDXLEN'((9 * p + 5) % DEPTH);
      if (p != 3) exp[p] = fq[0][(9 * p + 5) % DEPTH];
    end
    outrden = '1;
    outrden[3] = 1'b0;
    issue_reads();
    for (int p = 0; p < REPLICA; p++) begin
      n_checks++; if (outdvalid[p] !== (p != 3)) begin n_fail++; $display("FAIL multi_rden port %0d dvalid got %b", p, outdvalid[p]); end
      n_checks++; if (outdata[p] !== exp[p]) begin n_fail++; $display("FAIL multi_hold port %0d got %h want %h", p, outdata[p], exp[p]); end
    end
    release_frame();
  endtask

  task automatic test_outdone_edge();
    logic [31:0] exp [REPLICA];
    int a;
    release_frame();
    n_checks++; if (outvalid !== 1'b0 || inready !== 1'b1) begin n_fail++; $display("FAIL done_idle got ov=%b rdy=%b want 0/1", outvalid, inready); end
    send_frame(16'h0A00);
    for (int b = 0; b < BEATS; b++) begin
      invalid = 1'b1;
      outdone = (b == BEATS - 1);
      for (int k = 0; k < IN_WORDS; k++) indata[k] = {16'(16'h0B00 + b), 16'(k)};
      tick();
    end
    invalid = 1'b0;
    outdone = 1'b0;
    n_checks++; if (outvalid !== 1'b1) begin n_fail++; $display("FAIL done_coincide_ov got %b want 1", outvalid); end
    n_checks++; if (inready !== 1'b1) begin n_fail++; $display("FAIL done_coincide_rdy got %b want 1", inready); end
    for (int p = 0; p < REPLICA; p++) begin
      a = $urandom_range(0, DEPTH - 1);
      outaddr[p] = INDXLEN'(a);
      exp[p] = {16'(16'h0B00 + a / 16), 16'(a % 16)};
    end
    outrden = '1;
    issue_reads();
    for (int p = 0; p < REPLICA; p++) begin
      n_checks++; if (outdata[p] !== exp[p]) begin n_fail++; $display("FAIL done_frameB port %0d got %h want %h", p, outdata[p], exp[p]); end
    end
    release_frame();
    n_checks++; if (outvalid !== 1'b0) begin n_fail++; $display("FAIL done_final_ov got %b want 0", outvalid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    send_frame(16'd0);
    outrden = '1;
    for (int b = 0; b < 2; b++) begin
      invalid = 1'b1;
      for (int k = 0; k < IN_WORDS; k++) indata[k] = $urandom();
      tick();
    end
    set_idle();
    rstn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (inready !== 1'b1 || outvalid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_hs got rdy=%b ov=%b want 1/0", inready, outvalid); end
    for (int p = 0; p < REPLICA; p++) begin
      n_checks++; if (outdvalid[p] !== 1'b0 || outdata[p] !== 32'd0) begin n_fail++; $display("FAIL mid_reset_port %0d got %b/%h want 0/0", p, outdvalid[p], outdata[p]); end
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_frame(16'h0C00);
    for (int r = 0; r < DEPTH / REPLICA; r++) begin
      for (int p = 0; p < REPLICA; p++) outaddr[p] = INDXLEN'(r * REPLICA + p);
      outrden = '1;
      issue_reads();
      for (int p = 0; p < REPLICA; p++) begin
        w = {16'(16'h0C00 + (r * REPLICA + p) / 16), 16'((r * REPLICA + p) % 16)};
        n_checks++; if (outdvalid[p] !== 1'b1 || outdata[p] !== w) begin n_fail++; $display("FAIL mid_newdata addr %0d got %b/%h want 1/%h", r * REPLICA + p, outdvalid[p], outdata[p], w); end
      end
    end
    release_frame();
  endtask

  task automatic test_random();
    logic exp_rdy, exp_ov;
    for (int c = 0; c < 400; c++) begin
      invalid = ($urandom_range(0, 3) != 0);
      outdone = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < IN_WORDS; k++) indata[k] = $urandom();
      for (int p = 0; p < REPLICA; p++) begin
        outrden[p] = $urandom_range(0, 1);
        outaddr[p] = INDXLEN'($urandom_range(0, DEPTH - 1));
      end
      tick();
      exp_rdy = (fq.size() < 2);
      exp_ov  = (fq.size() > 0);
      n_checks++; if (inready !== exp_rdy) begin n_fail++; $display("FAIL rand_inready cyc %0d got %b want %b", c, inready, exp_rdy); end
      n_checks++; if (outvalid !== exp_ov) begin n_fail++; $display("FAIL rand_outvalid cyc %0d got %b want %b", c, outvalid, exp_ov); end
      for (int p = 0; p < REPLICA; p++) begin
        n_checks++; if (outdvalid[p] !== m_v[p]) begin n_fail++; $display("FAIL rand_dvalid cyc %0d port %0d got %b want %b", c, p, outdvalid[p], m_v[p]); end
        n_checks++; if (outdata[p] !== m_d[p]) begin n_fail++; $display("FAIL rand_data cyc %0d port %0d got %h want %h", c, p, outdata[p], m_d[p]); end
      end
    end
    set_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_multi_port();
    test_outdone_edge();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
